// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MEM-stage request port.
// Big-endian, bit order [0:31] (byte 0 of a word is bits [0:7]).
// Each access completes LATENCY cycles after it is presented; busy stalls the
// pipeline meanwhile and rValid pulses once on completion.
// Optional build macro: DMEM_ALIGN_CHECK_EN enables misaligned-access detection;
// without it, wider accesses are silently aligned down.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:31] addr,
    input  logic [0:31] wData,
    input  logic        writeEnable,
    input  logic        readEnable,
    input  logic [0:1]  dsize,
    input  logic        dsign,
    output logic [0:31] rData_out,
    output logic        rValid,
    output logic        busy,
    output logic        misaligned
);

    localparam int IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;
    localparam int CNT_W    = (CNT_INIT > 0) ? $clog2(CNT_INIT + 1) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    // request captured when it is accepted in IDLE
    logic [0:31]        l_addr;
    logic [0:31]        l_wdata;
    logic [0:1]         l_size;
    logic               l_sign;
    logic               l_store;

    logic [0:31]        mem [0:DEPTH_WORDS-1];

    logic               req;
    logic               take;
    logic               exec;
    logic [0:31]        x_addr;
    logic [0:31]        x_wdata;
    logic [0:1]         x_size;
    logic               x_sign;
    logic               x_store;
    logic [IDX_W-1:0]   idx;
    logic [0:1]         lane;
    logic               hsel;
    logic               is_byte;
    logic               is_half;
    logic               is_word;
    logic               mis;
    logic [0:3]         be;
    logic [0:31]        wd;
    logic [0:31]        rd_word;
    logic [0:7]         ld_b;
    logic [0:15]        ld_h;
    logic [0:31]        load_val;

    // a store wins when both enables are high
    assign req  = readEnable | writeEnable;
    assign busy = (state == WAIT) | req;
    assign take = (state == IDLE) & req;

    // with LATENCY=1 the access executes at the accepting edge, so the live
    // inputs are used directly; otherwise the captured copy is used
    assign exec = (LATENCY == 1) ? take : ((state == WAIT) && (cnt == '0));

    assign x_addr  = (state == IDLE) ? addr        : l_addr;
    assign x_wdata = (state == IDLE) ? wData       : l_wdata;
    assign x_size  = (state == IDLE) ? dsize       : l_size;
    assign x_sign  = (state == IDLE) ? dsign       : l_sign;
    assign x_store = (state == IDLE) ? writeEnable : l_store;

    // out-of-range word indices alias back into the array
    assign idx  = IDX_W'(x_addr[0:29] % 30'(DEPTH_WORDS));
    assign lane = x_addr[30:31];
    assign hsel = x_addr[30];

    assign is_byte = (x_size == 2'b10);
    assign is_half = (x_size == 2'b01);
    assign is_word = !is_byte && !is_half;

`ifdef DMEM_ALIGN_CHECK_EN
    assign mis = (is_half && x_addr[31]) || (is_word && (x_addr[30:31] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    // byte enables and lane-replicated store data for the selected size
    always_comb begin
        be = 4'b0000;
        wd = x_wdata;
        if (is_byte) begin
            be[lane] = 1'b1;
            wd       = {4{x_wdata[24:31]}};
        end else if (is_half) begin
            be[{hsel, 1'b0}] = 1'b1;
            be[{hsel, 1'b1}] = 1'b1;
            wd               = {2{x_wdata[16:31]}};
        end else begin
            be = 4'b1111;
        end
    end

    // load path: select lanes, right-justify, extend from the lane MSB
    always_comb begin
        rd_word = mem[idx];
        ld_b    = rd_word[{lane, 3'b000} +: 8];
        ld_h    = rd_word[{hsel, 4'b0000} +: 16];
        if (is_byte)
            load_val = {{24{x_sign & ld_b[0]}}, ld_b};
        else if (is_half)
            load_val = {{16{x_sign & ld_h[0]}}, ld_h};
        else
            load_val = rd_word;
    end

    // memory array: byte-lane writes, never cleared by reset
    always_ff @(posedge clk) begin
        if (reset && exec && x_store && !mis) begin
            for (int l = 0; l < 4; l++) begin
                if (be[l])
                    mem[idx][8*l +: 8] <= wd[8*l +: 8];
            end
        end
    end

    // control FSM with registered completion outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            l_addr     <= '0;
            l_wdata    <= '0;
            l_size     <= '0;
            l_sign     <= 1'b0;
            l_store    <= 1'b0;
            rValid     <= 1'b0;
            misaligned <= 1'b0;
            rData_out  <= '0;
        end else begin
            rValid     <= exec;
            misaligned <= exec & mis;
            if (exec && !x_store)
                rData_out <= mis ? '0 : load_val;
            case (state)
                IDLE: begin
                    if (take) begin
                        l_addr  <= addr;
                        l_wdata <= wData;
                        l_size  <= dsize;
                        l_sign  <= dsign;
                        l_store <= writeEnable;
                        if (LATENCY > 1) begin
                            state <= WAIT;
                            cnt   <= CNT_W'(CNT_INIT);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: reference memory model plus an expectation queue
// that is filled when each request is driven and drained on every rValid.
// Build with DMEM_ALIGN_CHECK_EN to match an RTL built with alignment checks.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wData;
    logic        writeEnable;
    logic        readEnable;
    logic [1:0]  dsize;
    logic        dsign;
    logic [31:0] rData_out;
    logic        rValid;
    logic        busy;
    logic        misaligned;

    typedef struct {
        bit        is_load;
        bit [31:0] rdata;
        bit        mis;
        int        cyc;
    } exp_t;

    exp_t        sb[$];
    bit   [31:0] mem_m [DEPTH];
    bit   [31:0] last_ld;
    int          cyc;
    int          n_chk;
    int          n_fail;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .wData       (wData),
        .writeEnable (writeEnable),
        .readEnable  (readEnable),
        .dsize       (dsize),
        .dsign       (dsign),
        .rData_out   (rData_out),
        .rValid      (rValid),
        .busy        (busy),
        .misaligned  (misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int widx(input bit [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic bit mis_m(input bit [31:0] a, input bit [1:0] sz);
`ifdef DMEM_ALIGN_CHECK_EN
        if (sz == 2'b01) return a[0];
        if (sz == 2'b10) return 1'b0;
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit [31:0] ld_m(input bit [31:0] a, input bit [1:0] sz, input bit sg);
        bit [31:0] w;
        bit [7:0]  b;
        bit [15:0] h;
        w = mem_m[widx(a)];
        case (sz)
            2'b10: begin
                b = w[31 - 8*a[1:0] -: 8];
                return {{24{sg & b[7]}}, b};
            end
            2'b01: begin
                h = a[1] ? w[15:0] : w[31:16];
                return {{16{sg & h[15]}}, h};
            end
            default: return w;
        endcase
    endfunction

    task automatic st_m(input bit [31:0] a, input bit [31:0] d, input bit [1:0] sz);
        int i;
        i = widx(a);
        case (sz)
            2'b10: mem_m[i][31 - 8*a[1:0] -: 8] = d[7:0];
            2'b01: if (a[1]) mem_m[i][15:0] = d[15:0]; else mem_m[i][31:16] = d[15:0];
            default: mem_m[i] = d;
        endcase
    endtask

    // drive one request at a negedge; returns at the negedge of its completion cycle
    task automatic access(input bit we, input bit re, input bit [31:0] a,
                          input bit [31:0] d, input bit [1:0] sz, input bit sg);
        exp_t e;
        writeEnable = we;
        readEnable  = re;
        addr        = a;
        wData       = d;
        dsize       = sz;
        dsign       = sg;
        e.is_load   = !we;
        e.mis       = mis_m(a, sz);
        e.cyc       = cyc + LAT;
        e.rdata     = '0;
        if (we) begin
            if (!e.mis) st_m(a, d, sz);
        end else begin
            e.rdata = e.mis ? 32'h0 : ld_m(a, sz, sg);
        end
        sb.push_back(e);
        for (int i = 0; i < LAT; i++) begin
            #1 chk("busy_active", busy, 1'b1);
            @(negedge clk);
            if (i < LAT - 1) begin
                // captured copy must be used; scramble the live operands
                addr  = $urandom;
                wData = $urandom;
                dsize = 2'($urandom_range(0, 3));
                dsign = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic idle(input int n);
        writeEnable = 1'b0;
        readEnable  = 1'b0;
        repeat (n) begin
            #1 chk("busy_idle", busy, 1'b0);
            @(negedge clk);
        end
    endtask

    // completion monitor
    always @(negedge clk) begin
        exp_t e;
        if (rValid) begin
            if (sb.size() == 0) begin
                chk("spurious_rvalid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rvalid_cycle", cyc, e.cyc);
                if (e.is_load) last_ld = e.rdata;
                chk("rdata", rData_out, last_ld);
                chk("misaligned", misaligned, e.mis);
            end
        end else if (reset) begin
            chk("misaligned_idle", misaligned, 1'b0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
        $fatal(1);
    end

    initial begin
        bit [31:0] a;
        bit [1:0]  sz;
        cyc = 0; n_chk = 0; n_fail = 0; last_ld = '0;
        reset = 1'b0; writeEnable = 1'b0; readEnable = 1'b0;
        addr = '0; wData = '0; dsize = '0; dsign = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rvalid", rValid, 1'b0);
        chk("rst_rdata", rData_out, 32'h0);
        chk("rst_mis", misaligned, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // give every word of the test region a known value
        for (int i = 0; i < 16; i++)
            access(1, 0, 32'(i * 4), 32'h0101_0101 * 32'(i + 1), 2'b00, 0);
        idle(1);

        // word store / load
        access(1, 0, 32'h10, 32'hDEADBEEF, 2'b00, 0); idle(1);
        access(0, 1, 32'h10, 0, 2'b00, 0);            idle(1);
        // byte loads with both extensions
        access(0, 1, 32'h13, 0, 2'b10, 1);            idle(1);
        access(0, 1, 32'h13, 0, 2'b10, 0);            idle(1);
        // half store, neighbours preserved
        access(1, 0, 32'h12, 32'h0000_1234, 2'b01, 0); idle(1);
        access(0, 1, 32'h10, 0, 2'b00, 0);             idle(1);
        access(1, 0, 32'h11, 32'hFFFF_FFA5, 2'b10, 0); idle(1);
        access(0, 1, 32'h10, 0, 2'b01, 1);             idle(1);
        access(0, 1, 32'h12, 0, 2'b01, 0);             idle(1);
        access(0, 1, 32'h10, 0, 2'b10, 0);             idle(1);
        // size 11 behaves as word
        access(0, 1, 32'h10, 0, 2'b11, 0);             idle(1);
        // back-to-back loads, then a store with both enables high, all without bubbles
        access(0, 1, 32'h10, 0, 2'b00, 0);
        access(0, 1, 32'h14, 0, 2'b00, 0);
        access(0, 1, 32'h18, 0, 2'b10, 1);
        access(1, 1, 32'h18, 32'h8899AABB, 2'b00, 0);
        access(0, 1, 32'h18, 0, 2'b00, 0);
        idle(2);
        // address aliasing past DEPTH words
        access(1, 0, 32'h10 + 32'(DEPTH * 4), 32'h5A5A_C3C3, 2'b00, 0); idle(1);
        access(0, 1, 32'h10, 0, 2'b00, 0);                              idle(1);
        // low address bits on wide accesses (error or align-down depending on build)
        access(0, 1, 32'h11, 0, 2'b00, 0);             idle(1);
        access(1, 0, 32'h11, 32'h7777_7777, 2'b00, 0); idle(1);
        access(0, 1, 32'h10, 0, 2'b00, 0);             idle(1);
        access(0, 1, 32'h13, 0, 2'b01, 1);             idle(1);

        // reset during the wait of a store: dropped, no completion
        access(1, 0, 32'h20, 32'h1122_3344, 2'b00, 0); idle(1);
        writeEnable = 1'b1; addr = 32'h20; wData = 32'hCAFEF00D; dsize = 2'b00;
        #1 chk("abort_busy", busy, 1'b1);
        @(negedge clk);
        reset = 1'b0; writeEnable = 1'b0;
        #1 chk("abort_busy_rst", busy, 1'b0);
        chk("abort_rdata_rst", rData_out, 32'h0);
        last_ld = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        access(0, 1, 32'h20, 0, 2'b00, 0); idle(1);

        // random traffic over the initialised region
        for (int i = 0; i < 40; i++) begin
            a  = 32'($urandom_range(0, 63));
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0)
                access(1, 1'($urandom_range(0, 1)), a, $urandom, sz, 0);
            else
                access(0, 1, a, 0, sz, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(3);

        chk("pending", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
